// File: rtl/cpu8227_bus_pkg.sv
// Shared constants and types for the top8227 bus memory/interrupt responder.
package cpu8227_bus_pkg;

   // Vector table base addresses (low byte; high byte at +1)
   localparam logic [15:0] VEC_NMI_ADDR   = 16'hFFFA;
   localparam logic [15:0] VEC_RESET_ADDR = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ_ADDR   = 16'hFFFE;

   // IO page register offsets
   localparam logic [7:0] IO_LOAD_LO = 8'd0;
   localparam logic [7:0] IO_LOAD_HI = 8'd1;
   localparam logic [7:0] IO_CTRL    = 8'd2;
   localparam logic [7:0] IO_STATUS  = 8'd3;

   localparam int unsigned IO_PAGE_SIZE = 256;

   // CTRL register bit positions
   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_AUTO   = 1;
   localparam int unsigned CTRL_NMISEL = 2;
   localparam int unsigned CTRL_W      = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } timer_state_t;

endpackage

// File: rtl/bus_interval_timer.sv
// Interval timer: down-counter, IDLE/RUN/EXPIRED FSM, pending flag and interrupt outputs.
module bus_interval_timer
   import cpu8227_bus_pkg::*;
#(
   parameter int unsigned TIMER_W = 16
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               startReq,    // CTRL write setting EN this cycle
   input  logic               effEn,       // EN as it will be after this cycle's CTRL write
   input  logic               effAuto,     // AUTO as it will be after this cycle's CTRL write
   input  logic               nmiSel,
   input  logic               pendClear,
   input  logic [TIMER_W-1:0] reloadVal,
   output logic [TIMER_W-1:0] timerCount,
   output logic               pend,
   output logic               irqOut,
   output logic               nmiOut,
   output logic               enClear_c    // one-shot finished: top clears EN
);

   timer_state_t       state;
   timer_state_t       stateNext;
   logic [TIMER_W-1:0] countNext;
   logic               expireNow;
   logic               pendNext;

   // Next-state and counter logic; the EXPIRED cycle counts as the first tick of an
   // auto-reload period so expiries are exactly reloadVal cycles apart.
   always_comb begin
      stateNext = state;
      countNext = timerCount;
      expireNow = 1'b0;
      enClear_c = 1'b0;
      case (state)
         IDLE: begin
            if (startReq && (reloadVal != '0)) begin
               stateNext = RUN;
               countNext = reloadVal;
            end
         end
         RUN: begin
            if (!effEn) begin
               stateNext = IDLE;
            end else if (timerCount <= TIMER_W'(1)) begin
               stateNext = EXPIRED;
               countNext = '0;
               expireNow = 1'b1;
            end else begin
               countNext = timerCount - TIMER_W'(1);
            end
         end
         EXPIRED: begin
            if (!effEn) begin
               stateNext = IDLE;
            end else if (effAuto && (reloadVal != '0)) begin
               if (reloadVal == TIMER_W'(1)) begin
                  expireNow = 1'b1;
               end else begin
                  stateNext = RUN;
                  countNext = reloadVal - TIMER_W'(1);
               end
            end else begin
               // single-shot done, or auto-reload with a zero reload: stop
               stateNext = IDLE;
               enClear_c = 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      // a new expiry beats a software clear in the same cycle
      pendNext = expireNow | (pend & ~pendClear);
   end

   // State, counter, pending flag and registered interrupt outputs
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         timerCount <= '0;
         pend       <= 1'b0;
         irqOut     <= 1'b0;
         nmiOut     <= 1'b0;
      end else begin
         state      <= stateNext;
         timerCount <= countNext;
         pend       <= pendNext;
         irqOut     <= pendNext & ~nmiSel;
         nmiOut     <= expireNow & nmiSel;
      end
   end

endmodule

// File: rtl/cpu_bus_memory_model.sv
// Memory and interrupt responder for the top8227 bus: address decode, RAM, vectors, IO timer.
module cpu_bus_memory_model
   import cpu8227_bus_pkg::*;
#(
   parameter int unsigned RAM_DEPTH    = 256,
   parameter int unsigned TIMER_W      = 16,
   parameter logic [15:0] RESET_VECTOR = 16'hCCDD,
   parameter logic [15:0] IRQ_VECTOR   = 16'hCC00,
   parameter logic [15:0] NMI_VECTOR   = 16'hCC80,
   parameter logic [15:0] IO_BASE      = 16'hFE00,
   parameter logic [7:0]  FILL_BYTE    = 8'hEA
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic [7:0]         AddressBusHigh,
   input  logic [7:0]         AddressBusLow,
   input  logic [7:0]         dataBusOutput,
   input  logic               writeEnable,
   output logic [7:0]         dataBusInput,
   output logic               interruptRequest,
   output logic               nonMaskableInterrupt,
   output logic [TIMER_W-1:0] timerCount
);

   localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);

   logic [15:0]        addr;
   logic [15:0]        ioOffset;
   logic [7:0]         ioReg;
   logic               vecHit;
   logic               ioHit;
   logic               ramHit;
   logic [RAM_AW-1:0]  ramIdx;
   logic [7:0]         ram [RAM_DEPTH];

   logic [7:0]         loadLo;
   logic [7:0]         loadHi;
   logic [CTRL_W-1:0]  ctrlReg;
   logic               ioWrite;
   logic               ctrlWrite;
   logic               pendClear;
   logic               effEn;
   logic               effAuto;
   logic               startReq;
   logic               enClear;
   logic               pend;
   logic [TIMER_W-1:0] reloadVal;

   // Decode: vectors > IO page > RAM > fill
   assign addr     = {AddressBusHigh, AddressBusLow};
   assign ioOffset = addr - IO_BASE;
   assign ioReg    = ioOffset[7:0];
   assign vecHit   = (addr >= VEC_NMI_ADDR);
   assign ioHit    = ~vecHit & (ioOffset < 16'(IO_PAGE_SIZE));
   assign ramHit   = ~vecHit & ~ioHit & (32'(addr) < RAM_DEPTH);
   assign ramIdx   = addr[RAM_AW-1:0];

   assign ioWrite   = writeEnable & ioHit;
   assign ctrlWrite = ioWrite & (ioReg == IO_CTRL);
   assign pendClear = ioWrite & (ioReg == IO_STATUS) & dataBusOutput[0];
   assign effEn     = ctrlWrite ? dataBusOutput[CTRL_EN]   : ctrlReg[CTRL_EN];
   assign effAuto   = ctrlWrite ? dataBusOutput[CTRL_AUTO] : ctrlReg[CTRL_AUTO];
   assign startReq  = ctrlWrite & dataBusOutput[CTRL_EN];
   // narrower timers drop high LOAD bits, wider ones zero-extend
   assign reloadVal = TIMER_W'({loadHi, loadLo});

   // RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (writeEnable && ramHit) begin
         ram[ramIdx] <= dataBusOutput;
      end
   end

   // IO registers; timer completion clears EN after any concurrent CTRL write
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         loadLo  <= '0;
         loadHi  <= '0;
         ctrlReg <= '0;
      end else begin
         if (ioWrite && (ioReg == IO_LOAD_LO)) loadLo <= dataBusOutput;
         if (ioWrite && (ioReg == IO_LOAD_HI)) loadHi <= dataBusOutput;
         if (ctrlWrite) ctrlReg <= dataBusOutput[CTRL_W-1:0];
         if (enClear) ctrlReg[CTRL_EN] <= 1'b0;
      end
   end

   // Zero-latency read data mux
   always_comb begin
      dataBusInput = FILL_BYTE;
      if (vecHit) begin
         case (addr)
            VEC_NMI_ADDR:           dataBusInput = NMI_VECTOR[7:0];
            VEC_NMI_ADDR + 16'd1:   dataBusInput = NMI_VECTOR[15:8];
            VEC_RESET_ADDR:         dataBusInput = RESET_VECTOR[7:0];
            VEC_RESET_ADDR + 16'd1: dataBusInput = RESET_VECTOR[15:8];
            VEC_IRQ_ADDR:           dataBusInput = IRQ_VECTOR[7:0];
            VEC_IRQ_ADDR + 16'd1:   dataBusInput = IRQ_VECTOR[15:8];
            default:                dataBusInput = FILL_BYTE;
         endcase
      end else if (ioHit) begin
         case (ioReg)
            IO_LOAD_LO: dataBusInput = loadLo;
            IO_LOAD_HI: dataBusInput = loadHi;
            IO_CTRL:    dataBusInput = {(8 - CTRL_W)'(0), ctrlReg};
            IO_STATUS:  dataBusInput = {7'd0, pend};
            default:    dataBusInput = FILL_BYTE;
         endcase
      end else if (ramHit) begin
         dataBusInput = ram[ramIdx];
      end
   end

   bus_interval_timer #(
      .TIMER_W (TIMER_W)
   ) uTimer (
      .clk        (clk),
      .nrst       (nrst),
      .startReq   (startReq),
      .effEn      (effEn),
      .effAuto    (effAuto),
      .nmiSel     (ctrlReg[CTRL_NMISEL]),
      .pendClear  (pendClear),
      .reloadVal  (reloadVal),
      .timerCount (timerCount),
      .pend       (pend),
      .irqOut     (interruptRequest),
      .nmiOut     (nonMaskableInterrupt),
      .enClear_c  (enClear)
   );

endmodule
